// File: rtl/gate_vector_sequencer.sv
// Exhaustive vector sequencer for small combinational gates.
//
// Walks dut_in through every value 0 .. 2^N_IN-1. Each value is held for
// SETTLE cycles (WAIT) and then sampled for one cycle (CHECK). In CHECK the
// gate outputs are compared against the golden outputs under cmp_mask. A
// one-cycle DONE state then raises done and publishes pass.
//
// Handshake: start is a level sampled only in IDLE; done is a one-cycle
// pulse with no back-pressure; abort returns to IDLE from any other state.
// The partial error statistics are kept on abort.
//
// All outputs, including the debug state, come straight from flops.
module gate_vector_sequencer #(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 2,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [N_OUT-1:0]  cmp_mask,
  input  logic [N_OUT-1:0]  dut_out,
  input  logic [N_OUT-1:0]  exp_out,
  output logic [N_IN-1:0]   dut_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count,
  output logic [N_IN-1:0]   first_fail_vec,
  output logic              first_fail_valid,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [7:0]      SETTLE_M1 = 8'(SETTLE - 1);
  localparam logic [N_IN-1:0] VEC_ONE   = 1;
  localparam logic [N_IN-1:0] VEC_LAST  = '1;
  localparam logic [N_IN:0]   ERR_ONE   = 1;

  state_t             state_q, state_d;
  logic [7:0]         wait_q, wait_d;
  logic [N_IN-1:0]    dut_in_d;
  logic [N_IN:0]      err_d;
  logic [N_IN-1:0]    ffv_d;
  logic               ffvalid_d;
  logic               pass_d;
  logic               busy_d;
  logic               done_d;
  logic               mismatch;

  // Only enabled output bits can produce a mismatch.
  assign mismatch  = |((dut_out ^ exp_out) & cmp_mask);
  assign state_dbg = state_q;

  // Next-state and next-output logic; abort overrides the CHECK update.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    dut_in_d  = dut_in;
    err_d     = err_count;
    ffv_d     = first_fail_vec;
    ffvalid_d = first_fail_valid;
    pass_d    = pass;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          err_d     = '0;
          ffvalid_d = 1'b0;
          pass_d    = 1'b0;
          dut_in_d  = '0;
          wait_d    = SETTLE_M1;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          dut_in_d = '0;
          state_d  = S_IDLE;
        end else if (wait_q == 8'd0) begin
          state_d = S_CHECK;
        end else begin
          wait_d = wait_q - 8'd1;
        end
      end
      S_CHECK: begin
        if (abort) begin
          dut_in_d = '0;
          state_d  = S_IDLE;
        end else begin
          if (mismatch) begin
            err_d = err_count + ERR_ONE;
            if (!first_fail_valid) begin
              ffv_d     = dut_in;
              ffvalid_d = 1'b1;
            end
          end
          if (dut_in == VEC_LAST) begin
            // pass is published together with done, using the final count.
            pass_d  = (err_d == '0);
            state_d = S_DONE;
          end else begin
            dut_in_d = dut_in + VEC_ONE;
            wait_d   = SETTLE_M1;
            state_d  = S_WAIT;
          end
        end
      end
      S_DONE: begin
        dut_in_d = '0;
        state_d  = S_IDLE;
      end
      default: begin
        dut_in_d = '0;
        state_d  = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_WAIT) || (state_d == S_CHECK);
    done_d = (state_d == S_DONE);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      wait_q           <= 8'd0;
      dut_in           <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      state_q          <= state_d;
      wait_q           <= wait_d;
      dut_in           <= dut_in_d;
      busy             <= busy_d;
      done             <= done_d;
      pass             <= pass_d;
      err_count        <= err_d;
      first_fail_vec   <= ffv_d;
      first_fail_valid <= ffvalid_d;
    end
  end

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Bench for gate_vector_sequencer: a Mux sweep (3 in, 1 out, SETTLE=1) and a
// DMux sweep (2 in, 2 out, SETTLE=3), both with injectable gate faults.
module tb_gate_vector_sequencer;

  localparam int A_HOLD = 2;  // SETTLE + 1 for instance a
  localparam int B_HOLD = 4;  // SETTLE + 1 for instance b
  localparam int W      = 35; // {pass, ffvalid, ffv[7:0], err[8:0], lat[15:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- instance a: Mux ----------------
  logic       start_a = 0, abort_a = 0;
  logic [0:0] mask_a = 1'b1;
  logic [0:0] out_a, exp_a;
  logic [2:0] in_a;
  logic       busy_a, done_a, pass_a, ffval_a;
  logic [3:0] err_a;
  logic [2:0] ffv_a;
  logic [1:0] st_a;
  logic       fault_en_a = 0;
  logic [2:0] fault_vec_a = 0;

  function automatic logic mux_gold(input logic [2:0] v);
    return v[2] ? v[1] : v[0];
  endfunction

  assign exp_a = mux_gold(in_a);
  assign out_a = mux_gold(in_a) ^ (fault_en_a && (in_a == fault_vec_a));

  gate_vector_sequencer #(.N_IN(3), .N_OUT(1), .SETTLE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .cmp_mask(mask_a), .dut_out(out_a), .exp_out(exp_a), .dut_in(in_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_fail_vec(ffv_a), .first_fail_valid(ffval_a), .state_dbg(st_a)
  );

  // ---------------- instance b: DMux ----------------
  logic       start_b = 0, abort_b = 0;
  logic [1:0] mask_b = 2'b11;
  logic [1:0] out_b, exp_b;
  logic [1:0] in_b;
  logic       busy_b, done_b, pass_b, ffval_b;
  logic [2:0] err_b;
  logic [1:0] ffv_b;
  logic [1:0] st_b;
  logic       stuck_b = 0;

  // in = bit0, sel = bit1; result is {b, a}
  function automatic logic [1:0] dmux_gold(input logic [1:0] v);
    return {v[0] & v[1], v[0] & ~v[1]};
  endfunction

  assign exp_b = dmux_gold(in_b);
  assign out_b = dmux_gold(in_b) & {~stuck_b, 1'b1};

  gate_vector_sequencer #(.N_IN(2), .N_OUT(2), .SETTLE(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .cmp_mask(mask_b), .dut_out(out_b), .exp_out(exp_b), .dut_in(in_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_fail_vec(ffv_b), .first_fail_valid(ffval_b), .state_dbg(st_b)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic p, input logic fv, input logic [7:0] ffv,
                          input logic [8:0] err, input logic [15:0] lat);
    exp_q.push_back({p, fv, ffv, err, lat});
  endtask

  // Pops one expectation and compares it with an observed result.
  task automatic score(input string who, input logic p, input logic fv,
                       input logic [7:0] ffv, input logic [8:0] err,
                       input logic [15:0] lat, input bit chk_lat);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check({who, "_queue_empty"}, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    check({who, "_pass"}, p, e[34]);
    check({who, "_ff_valid"}, fv, e[33]);
    if (e[33]) check({who, "_ff_vec"}, ffv, e[32:25]);
    check({who, "_err_count"}, err, e[24:16]);
    if (chk_lat) check({who, "_latency"}, lat, e[15:0]);
  endtask

  // ---------------- driver / monitor: instance a ----------------
  task automatic run_a(input logic fen, input logic [2:0] fvec);
    int err = 0, ffv = 0, cyc = 0, run = 0, prev = 0;
    bit fv = 0, got = 0, first = 1;
    for (int v = 0; v < 8; v++)
      if (fen && v == fvec) begin
        err++;
        if (!fv) begin ffv = v; fv = 1; end
      end
    push_exp(err == 0, fv, 8'(ffv), 9'(err), 16'(8 * A_HOLD));
    @(negedge clk);
    fault_en_a = fen; fault_vec_a = fvec; start_a = 1;
    @(posedge clk);
    while (cyc < 200 && !got) begin
      @(negedge clk);
      start_a = 0;
      if (done_a) got = 1;
      else begin
        if (busy_a) begin
          if (first) begin
            check("a_first_vec", in_a, 0); prev = in_a; run = 1; first = 0;
          end else if (in_a == prev) run++;
          else begin
            check("a_hold", run, A_HOLD); check("a_step", in_a, prev + 1);
            prev = in_a; run = 1;
          end
        end
        @(posedge clk); cyc++;
      end
    end
    if (!got) begin check("a_done_timeout", 0, 1); return; end
    check("a_last_hold", run, A_HOLD);
    check("a_last_vec", prev, 7);
    check("a_busy_in_done", busy_a, 0);
    score("a", pass_a, ffval_a, 8'(ffv_a), 9'(err_a), 16'(cyc), 1);
    @(negedge clk);
    check("a_done_pulse", done_a, 0);
    check("a_dut_in_idle", in_a, 0);
    check("a_pass_held", pass_a, err == 0);
  endtask

  // ---------------- driver / monitor: instance b ----------------
  task automatic run_b(input logic stuck, input logic [1:0] mask, input bit noisy);
    int err = 0, ffv = 0, cyc = 0, run = 0, prev = 0, extra = 0, busy_seen = 0;
    bit fv = 0, got = 0, first = 1;
    for (int v = 0; v < 4; v++) begin
      logic [1:0] g, f;
      g = dmux_gold(2'(v));
      f = g & {~stuck, 1'b1};
      if (((g ^ f) & mask) != 2'b00) begin
        err++;
        if (!fv) begin ffv = v; fv = 1; end
      end
    end
    push_exp(err == 0, fv, 8'(ffv), 9'(err), 16'(4 * B_HOLD));
    @(negedge clk);
    stuck_b = stuck; mask_b = mask; start_b = 1;
    @(posedge clk);
    while (cyc < 200 && !got) begin
      @(negedge clk);
      start_b = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      if (done_b) got = 1;
      else begin
        if (busy_b) begin
          if (first) begin
            check("b_first_vec", in_b, 0); prev = in_b; run = 1; first = 0;
          end else if (in_b == prev) run++;
          else begin
            check("b_hold", run, B_HOLD); check("b_step", in_b, prev + 1);
            prev = in_b; run = 1;
          end
        end
        @(posedge clk); cyc++;
      end
    end
    if (!got) begin start_b = 0; check("b_done_timeout", 0, 1); return; end
    check("b_last_hold", run, B_HOLD);
    check("b_last_vec", prev, 3);
    score("b", pass_b, ffval_b, 8'(ffv_b), 9'(err_b), 16'(cyc), 1);
    // start asserted during the DONE cycle must not launch a new sweep
    start_b = noisy;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start_b = 0;
      if (done_b) extra++;
      if (busy_b) busy_seen++;
    end
    check("b_extra_done", extra, 0);
    check("b_restart_busy", busy_seen, 0);
    check("b_dut_in_idle", in_b, 0);
  endtask

  // ---------------- abort scenario on instance a ----------------
  task automatic abort_a_test();
    int err = 0, ffv = 0, cyc = 0, dones = 0;
    bit fv = 0, hit = 0;
    for (int v = 0; v < 3; v++)
      if (v == 1) begin
        err++;
        if (!fv) begin ffv = v; fv = 1; end
      end
    push_exp(1'b0, fv, 8'(ffv), 9'(err), 16'd0);
    @(negedge clk);
    fault_en_a = 1; fault_vec_a = 3'd1; start_a = 1;
    @(posedge clk);
    while (cyc < 100 && !hit) begin
      @(negedge clk);
      start_a = 0;
      if (done_a) dones++;
      if (st_a == 2'd1 && in_a == 3'd3) hit = 1;
      else begin @(posedge clk); cyc++; end
    end
    if (!hit) begin check("abort_reach_vec3", 0, 1); return; end
    abort_a = 1;
    @(posedge clk);
    @(negedge clk);
    abort_a = 0;
    if (done_a) dones++;
    check("abort_state_idle", st_a, 0);
    check("abort_dut_in", in_a, 0);
    check("abort_busy", busy_a, 0);
    score("abort", pass_a, ffval_a, 8'(ffv_a), 9'(err_a), 16'd0, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_a) dones++;
    end
    check("abort_no_done", dones, 0);
    check("abort_stays_idle", st_a, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("rst_dut_in", in_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_pass", pass_a, 0);
    check("rst_err", err_a, 0);
    check("rst_ffv", ffv_a, 0);
    check("rst_ffval", ffval_a, 0);
    check("rst_state", st_a, 0);
    check("rst_b_err", err_b, 0);
    rst_n = 1;
    @(negedge clk);

    // start and abort together in IDLE: abort wins
    start_a = 1; abort_a = 1;
    @(negedge clk);
    start_a = 0; abort_a = 0;
    check("start_abort_busy", busy_a, 0);
    check("start_abort_state", st_a, 0);

    run_a(1'b0, 3'd0);           // clean Mux
    run_a(1'b1, 3'd5);           // fault at vector 5
    abort_a_test();              // fault at 1, abort in WAIT of 3
    run_b(1'b1, 2'b11, 0);       // DMux bit1 stuck, full mask
    run_b(1'b1, 2'b01, 1);       // bit1 masked off, noisy start
    run_b(1'b1, 2'($urandom_range(0, 3)), 0);

    // asynchronous reset in the middle of a sweep
    @(negedge clk);
    fault_en_a = 0; start_a = 1;
    @(negedge clk);
    start_a = 0;
    for (int i = 0; i < 50 && in_a != 3'd4; i++) @(negedge clk);
    check("rst_mid_reach_vec4", in_a, 4);
    #2 rst_n = 0;
    #1;
    check("rst_mid_dut_in", in_a, 0);
    check("rst_mid_busy", busy_a, 0);
    check("rst_mid_err", err_a, 0);
    check("rst_mid_ffv", ffv_a, 0);
    check("rst_mid_ffval", ffval_a, 0);
    check("rst_mid_state", st_a, 0);
    @(negedge clk);
    rst_n = 1;
    run_a(1'b0, 3'd0);

    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
